key_tone_gen: RTL and testbench

- Multi-channel successor to the fixed key-to-frequency decoder.
- Accepts note-on/note-off commands over a valid/ready handshake and applies a signed semitone transpose.
- Computes each channel's half-period divisor with a shared serial divider, then drives one square-wave tone output per channel.
- Sits between the key scanner/encoder and the audio mixer/PWM stage.

---
 rtl/key_tone_gen.sv | 187 ++++++++++++++++++
 tb/tb_key_tone_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_tone_gen.sv
// Multi-channel key-to-tone generator: note-on/off commands with transpose, a shared
// serial divider for the half-period, and one square-wave output per channel.
module key_tone_gen #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned FREQ_W = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [CH_W-1:0]          key_ch,
    input  logic [5:0]               key_code,
    input  logic                     key_on,
    input  logic [5:0]               transpose,
    output logic [NUM_CH*FREQ_W-1:0] freq,
    output logic [NUM_CH-1:0]        active,
    output logic [NUM_CH-1:0]        tone,
    output logic                     err
);

    localparam int unsigned CNT_W = $clog2(FREQ_W + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, DIV, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     ch_q;
    logic [5:0]          code_q;
    logic                on_q;
    logic [5:0]          trn_q;
    logic                reject_q;
    logic [FREQ_W-1:0]   f_q, dvsr_q, rem_q, quo_q;
    logic [CNT_W-1:0]    div_cnt;
    logic [FREQ_W-1:0]   freq_r [NUM_CH];
    logic [FREQ_W-1:0]   half_r [NUM_CH];
    logic [FREQ_W-1:0]   cnt_r  [NUM_CH];

    logic                accept_c, reject_c, div_done_c, commit_c;
    logic signed [7:0]   idx_c;
    logic [10:0]         tbl_c;
    logic [FREQ_W:0]     rem_sh_c, diff_c;
    logic [FREQ_W-1:0]   half_c;

    // Equal-tempered key table, C3 .. B6 in whole Hz
    function automatic logic [10:0] tone_hz(input logic [5:0] i);
        logic [10:0] f;
        f = 11'd0;
        case (i)
            6'd0:  f = 11'd130;  6'd1:  f = 11'd138;  6'd2:  f = 11'd146;  6'd3:  f = 11'd155;
            6'd4:  f = 11'd164;  6'd5:  f = 11'd174;  6'd6:  f = 11'd185;  6'd7:  f = 11'd196;
            6'd8:  f = 11'd207;  6'd9:  f = 11'd220;  6'd10: f = 11'd233;  6'd11: f = 11'd246;
            6'd12: f = 11'd261;  6'd13: f = 11'd277;  6'd14: f = 11'd293;  6'd15: f = 11'd311;
            6'd16: f = 11'd329;  6'd17: f = 11'd349;  6'd18: f = 11'd369;  6'd19: f = 11'd392;
            6'd20: f = 11'd415;  6'd21: f = 11'd440;  6'd22: f = 11'd466;  6'd23: f = 11'd493;
            6'd24: f = 11'd523;  6'd25: f = 11'd554;  6'd26: f = 11'd587;  6'd27: f = 11'd622;
            6'd28: f = 11'd659;  6'd29: f = 11'd698;  6'd30: f = 11'd739;  6'd31: f = 11'd783;
            6'd32: f = 11'd830;  6'd33: f = 11'd880;  6'd34: f = 11'd932;  6'd35: f = 11'd987;
            6'd36: f = 11'd1046; 6'd37: f = 11'd1108; 6'd38: f = 11'd1174; 6'd39: f = 11'd1244;
            6'd40: f = 11'd1318; 6'd41: f = 11'd1396; 6'd42: f = 11'd1480; 6'd43: f = 11'd1568;
            6'd44: f = 11'd1661; 6'd45: f = 11'd1760; 6'd46: f = 11'd1864; 6'd47: f = 11'd1975;
            default: f = 11'd0;
        endcase
        return f;
    endfunction

    assign accept_c   = key_valid && key_ready;
    assign idx_c      = $signed({2'b00, code_q}) + $signed({{2{trn_q[5]}}, trn_q});
    assign reject_c   = (32'(ch_q) >= NUM_CH) ||
                        (on_q && ((code_q > 6'd47) || idx_c[7] || (idx_c > 8'sd47)));
    assign tbl_c      = tone_hz(idx_c[5:0]);
    assign div_done_c = (div_cnt == CNT_W'(FREQ_W - 1));
    assign commit_c   = (state == COMMIT) && !reject_q;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    assign rem_sh_c = {rem_q, quo_q[FREQ_W-1]};
    assign diff_c   = rem_sh_c - {1'b0, dvsr_q};
    assign half_c   = (quo_q == '0) ? FREQ_W'(1) : quo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = (reject_c || !on_q) ? COMMIT : DIV;
            DIV:     if (div_done_c) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, divider datapath and per-channel tone generators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready <= 1'b1;
            err       <= 1'b0;
            ch_q      <= '0;
            code_q    <= '0;
            on_q      <= 1'b0;
            trn_q     <= '0;
            reject_q  <= 1'b0;
            f_q       <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt   <= '0;
            active    <= '0;
            tone      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                freq_r[c] <= '0;
                half_r[c] <= '0;
                cnt_r[c]  <= '0;
            end
        end else begin
            // Registered ready rises one cycle after IDLE is re-entered
            key_ready <= (state == IDLE) && !accept_c;
            err       <= 1'b0;

            if (accept_c) begin
                ch_q   <= key_ch;
                code_q <= key_code;
                on_q   <= key_on;
                trn_q  <= transpose;
            end

            case (state)
                LOOKUP: begin
                    reject_q <= reject_c;
                    f_q      <= FREQ_W'(tbl_c);
                    dvsr_q   <= FREQ_W'({tbl_c, 1'b0});
                    rem_q    <= '0;
                    quo_q    <= FREQ_W'(CLK_HZ);
                    div_cnt  <= '0;
                end
                DIV: begin
                    if (!diff_c[FREQ_W]) begin
                        rem_q <= diff_c[FREQ_W-1:0];
                        quo_q <= {quo_q[FREQ_W-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh_c[FREQ_W-1:0];
                        quo_q <= {quo_q[FREQ_W-2:0], 1'b0};
                    end
                    div_cnt <= div_cnt + CNT_W'(1);
                end
                COMMIT: if (reject_q) err <= 1'b1;
                default: ;
            endcase

            for (int c = 0; c < NUM_CH; c++) begin
                if (active[c]) begin
                    if (cnt_r[c] == half_r[c] - FREQ_W'(1)) begin
                        cnt_r[c] <= '0;
                        tone[c]  <= ~tone[c];
                    end else begin
                        cnt_r[c] <= cnt_r[c] + FREQ_W'(1);
                    end
                end else begin
                    cnt_r[c] <= '0;
                    tone[c]  <= 1'b0;
                end

                // Commit overrides the running generator and restarts its phase
                if (commit_c && (int'(ch_q) == c)) begin
                    cnt_r[c] <= '0;
                    tone[c]  <= 1'b0;
                    if (on_q) begin
                        freq_r[c] <= f_q;
                        half_r[c] <= half_c;
                        active[c] <= 1'b1;
                    end else begin
                        freq_r[c] <= '0;
                        active[c] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_freq
        assign freq[c*FREQ_W +: FREQ_W] = freq_r[c];
    end

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen: scoreboard of expected commits, tone period
// measurement, reject/handshake timing and reset during division.
module tb_key_tone_gen;

    localparam int unsigned CLK_HZ = 100000;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned FREQ_W = 32;
    localparam int unsigned CH_W   = 2;

    typedef struct {
        int          ch;
        logic [31:0] freq;
        logic        err;
        int          half;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst;
    logic key_valid, key_ready, key_on, err;
    logic [CH_W-1:0] key_ch;
    logic [5:0] key_code, transpose;
    logic [NUM_CH*FREQ_W-1:0] freq;
    logic [NUM_CH-1:0] active, tone;
    logic key_ready3, err3;
    logic [3*FREQ_W-1:0] freq3;
    logic [2:0] active3, tone3;

    int tbl [48] = '{130,138,146,155,164,174,185,196,207,220,233,246,
                     261,277,293,311,329,349,369,392,415,440,466,493,
                     523,554,587,622,659,698,739,783,830,880,932,987,
                     1046,1108,1174,1244,1318,1396,1480,1568,1661,1760,1864,1975};

    logic [31:0] m_freq [NUM_CH];
    logic [NUM_CH-1:0] m_act;
    exp_t sb [$];

    always #5 clk = ~clk;

    key_tone_gen #(.CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W)) u_dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_ch(key_ch), .key_code(key_code), .key_on(key_on), .transpose(transpose),
        .freq(freq), .active(active), .tone(tone), .err(err)
    );

    // Three-channel copy sharing the command bus, so channel 3 is out of range there
    key_tone_gen #(.CLK_HZ(CLK_HZ), .NUM_CH(3), .FREQ_W(FREQ_W)) u_dut3 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready3),
        .key_ch(key_ch), .key_code(key_code), .key_on(key_on), .transpose(transpose),
        .freq(freq3), .active(active3), .tone(tone3), .err(err3)
    );

    function automatic logic [31:0] chan_freq(input int c);
        return freq[c*FREQ_W +: FREQ_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_channels();
        for (int c = 0; c < NUM_CH; c++) check("chan_freq", chan_freq(c), m_freq[c]);
        check("active", active, m_act);
    endtask

    // Wait for ready, present one command, return #1 after the acceptance edge
    task automatic issue(input int ch, input int code, input logic on, input int trn);
        int w;
        w = 0;
        @(negedge clk);
        while (key_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", key_ready, 1);
        key_valid = 1'b1;
        key_ch    = CH_W'(ch);
        key_code  = 6'(code);
        key_on    = on;
        transpose = 6'(trn);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("ready_drop", key_ready, 0);
    endtask

    task automatic cmd(input int ch, input int code, input logic on, input int trn, output int half);
        exp_t e;
        int idx;
        idx    = code + trn;
        e.ch   = ch;
        e.err  = (ch >= int'(NUM_CH)) || (on && (code > 47 || idx < 0 || idx > 47));
        e.freq = m_freq[ch];
        e.half = 0;
        if (!e.err && on) begin
            e.freq = tbl[idx];
            e.half = int'(CLK_HZ) / (2 * tbl[idx]);
            if (e.half == 0) e.half = 1;
        end else if (!e.err) begin
            e.freq = 0;
        end
        sb.push_back(e);

        issue(ch, code, on, trn);
        if (!e.err && on) begin
            wait_edges(FREQ_W + 1);
            check("pre_commit_freq", chan_freq(ch), m_freq[ch]);
            check("pre_commit_active", active[ch], m_act[ch]);
            check("busy_ready", key_ready, 0);
            wait_edges(1);
        end else begin
            wait_edges(1);
            check("err_early", err, 0);
            wait_edges(1);
            if (ch == 3 && !on) check("err3_pulse", err3, 1);
        end

        e = sb.pop_front();
        if (!e.err) begin
            m_freq[e.ch] = e.freq;
            m_act[e.ch]  = (e.freq != 0);
            check("tone_restart", tone[e.ch], 0);
        end
        check("err_pulse", err, e.err);
        check("ready_commit", key_ready, 0);
        check_all_channels();
        wait_edges(1);
        check("err_clear", err, 0);
        check("ready_back", key_ready, 1);
        half = e.half;
    endtask

    // Called at commit+1: first toggle at commit+half, then every half cycles
    task automatic measure(input int ch, input int half);
        int k;
        logic prev;
        for (int rep = 0; rep < 2; rep++) begin
            prev = tone[ch];
            k = (rep == 0) ? 1 : 0;
            do begin
                wait_edges(1);
                k++;
            end while (tone[ch] === prev && k < 4000);
            check("tone_half", k, half);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h;
        int acc;
        logic prev_err3;
        rst = 1'b1;
        key_valid = 1'b0;
        key_ch = '0;
        key_code = '0;
        key_on = 1'b0;
        transpose = '0;
        for (int c = 0; c < NUM_CH; c++) m_freq[c] = 0;
        m_act = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", key_ready, 1);
        check("rst_freq", freq, 0);
        check("rst_active", active, 0);
        check("rst_tone", tone, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(2);
        check("idle_freq", freq, 0);
        check("idle_ready", key_ready, 1);

        cmd(1, 21, 1'b1, 0, h);
        measure(1, h);
        cmd(0, 9, 1'b1, 12, h);
        cmd(3, 40, 1'b1, -28, h);
        measure(3, h);

        cmd(0, 47, 1'b1, 1, h);
        cmd(0, 50, 1'b1, 0, h);
        cmd(0, 2, 1'b1, -5, h);
        cmd(3, 0, 1'b0, 0, h);

        cmd(2, 21, 1'b1, 0, h);
        cmd(2, 0, 1'b0, 0, h);
        check("ch1_untouched", chan_freq(1), 440);

        cmd(1, 33, 1'b1, 0, h);
        measure(1, h);

        // key_valid held high: one acceptance per IDLE visit (every 4 cycles)
        acc = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_ch    = 2'd3;
        key_code  = 6'd0;
        key_on    = 1'b0;
        transpose = 6'd0;
        for (int i = 0; i < 12; i++) begin
            if (key_ready) acc++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("b2b_accepts", acc, 3);
        wait_edges(6);
        check_all_channels();

        // Reset in the middle of a division
        issue(0, 21, 1'b1, 0);
        wait_edges(10);
        rst = 1'b1;
        #1;
        check("midrst_freq", freq, 0);
        check("midrst_active", active, 0);
        check("midrst_tone", tone, 0);
        check("midrst_ready", key_ready, 1);
        for (int c = 0; c < NUM_CH; c++) m_freq[c] = 0;
        m_act = '0;
        wait_edges(3);
        @(negedge clk);
        rst = 1'b0;
        prev_err3 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_edges(1);
            if (active != 0 || err3) prev_err3 = 1'b1;
        end
        check("no_late_commit", prev_err3, 0);
        check("post_rst_freq", freq, 0);

        cmd(2, 0, 1'b1, 0, h);
        measure(2, h);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
